// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues word-aligned reads to the
//            instruction memory, delivers each fetched word with its PC
//            through a single output register with a valid/ready handshake,
//            and honours taken branches from the execute stage. A branch
//            that arrives while a read is outstanding is parked in DRAIN
//            until the stale response returns; that response is discarded.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC    : first fetch address after reset (bits [1:0] must be 00)
//   NOP_INSTR   : value presented on instr while instr_valid is low
// Ports
//   clk         : in  - clock, all state updates on the rising edge
//   rst_n       : in  - asynchronous active-low reset
//   branch      : in  - execute stage holds a conditional branch
//   zero_flag   : in  - ALU zero result from the execute stage
//   pc_branch   : in  - branch target, bits [1:0] are ignored
//   imem_req    : out - instruction-memory read request
//   imem_addr   : out - word-aligned read address
//   imem_ack    : in  - read complete, imem_rdata valid this cycle
//   imem_rdata  : in  - instruction word
//   instr       : out - fetched instruction to decode
//   pc          : out - address of instr
//   instr_valid : out - instr and pc are valid
//   instr_ready : in  - downstream accepts instr this cycle
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic        zero_flag,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] target_q,      target_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_redirect;
    logic        w_handshake;
    logic        w_out_free;
    logic        w_req;
    logic        w_complete;
    logic [31:0] w_branch_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_drain_target;
    logic        w_unused_pc_bits;

    assign w_redirect  = branch & zero_flag;
    assign w_handshake = instr_valid_q & instr_ready;
    // The output register can take a new word this cycle if it is empty or
    // its current word is being handed off right now.
    assign w_out_free  = ~instr_valid_q | instr_ready;

    // Targets are always forced onto a word boundary.
    assign w_branch_pc      = {pc_branch[31:2], 2'b00};
    assign w_unused_pc_bits = ^pc_branch[1:0];

    // Plain 32-bit add, wraps naturally from 32'hFFFF_FFFC to 0.
    assign w_pc_plus4 = fetch_pc_q + 32'd4;

    // A redirect landing in DRAIN replaces the parked target, including in
    // the very cycle the stale response returns.
    assign w_drain_target = w_redirect ? w_branch_pc : target_q;

    // Request generation. In REQ a new read is only started while the output
    // register has room, so a returning word can never overwrite one that
    // decode has not taken yet. Once a read is issued the register is empty,
    // so the request stays high until the ack.
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            ST_REQ:   w_req = w_out_free;
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    // An ack without a request is ignored.
    assign w_complete = w_req & imem_ack;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        target_d      = target_q;

        // A handed-off word leaves the register empty unless a capture below
        // refills it in the same cycle.
        if (w_handshake) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
        end

        // A taken branch flushes whatever is in the output register; the
        // capture paths below are all gated off when it is set.
        if (w_redirect) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                if (w_redirect) begin
                    fetch_pc_d = w_branch_pc;
                end
            end

            ST_REQ: begin
                if (w_redirect) begin
                    if (w_req && !imem_ack) begin
                        // A read is in flight: its response must be drained
                        // before the new target can be requested.
                        target_d = w_branch_pc;
                        state_d  = ST_DRAIN;
                    end else begin
                        // Nothing outstanding (or it completes now and is
                        // dropped): go straight to the target.
                        fetch_pc_d = w_branch_pc;
                        state_d    = ST_REQ;
                    end
                end else if (w_complete) begin
                    instr_d       = imem_rdata;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    fetch_pc_d    = w_pc_plus4;
                    state_d       = w_out_free ? ST_REQ : ST_WAIT;
                end else if (!w_req) begin
                    // Output register full and not accepted: park in WAIT.
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (w_redirect) begin
                    fetch_pc_d = w_branch_pc;
                    state_d    = ST_REQ;
                end else if (w_handshake) begin
                    state_d = ST_REQ;
                end
            end

            ST_DRAIN: begin
                // The old address stays on imem_addr; the response is dropped.
                target_d = w_drain_target;
                if (w_complete) begin
                    fetch_pc_d = w_drain_target;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            target_q      <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            target_q      <= target_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req    = w_req;
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;

endmodule
`default_nettype wire
